// File: rtl/popcount_stream_if.sv
// Stream bundle for popcount_stream: word input side and count/total output side.
// The master modport drives words in and consumes results; the slave modport is the counter.
interface popcount_stream_if #(
  parameter int W     = 9,
  parameter int ACC_W = 16
);
  localparam int CW = $clog2(W + 1);

  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both 1. Once valid is raised, the payload must hold until that
  // transfer. Ready may depend on state but never on the same side's valid.
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_cnt;
  logic [ACC_W-1:0] out_total;
  logic             out_last;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_cnt, out_total, out_last, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_cnt, out_total, out_last, out_ovf
  );
endinterface

// File: rtl/popcount_stream.sv
// Two-stage pipelined ones-counter with a per-frame running total and sticky overflow.
// Define POPCOUNT_SAT_EN to saturate the frame total instead of wrapping it.
module popcount_stream #(
  parameter int W     = 9,
  parameter int ACC_W = 16
) (
  input logic              clk,
  input logic              rst,
  popcount_stream_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  logic             s1_valid;
  logic [CW-1:0]    s1_cnt;
  logic             s1_last;

  logic             s2_valid;
  logic [CW-1:0]    s2_cnt;
  logic [ACC_W-1:0] s2_total;
  logic             s2_last;
  logic             s2_ovf;

  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;

  logic             s2_adv;
  logic             s1_to_s2;
  logic             s1_adv;
  logic             accept;
  logic [CW-1:0]    in_cnt;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] new_total;
  logic             new_ovf;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] d);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      n = n + CW'(d[i]);
    end
    return n;
  endfunction

  // S2 frees up when empty or being consumed; S1 frees up when empty or draining into S2.
  always_comb begin
    s2_adv   = !s2_valid || bus.out_ready;
    s1_to_s2 = s1_valid && s2_adv;
    s1_adv   = !s1_valid || s2_adv;
    accept   = bus.in_valid && bus.in_ready;
    in_cnt   = popcount(bus.in_data);
  end

  // One extra bit on the add exposes the carry-out used for overflow detection.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - CW){1'b0}}, s1_cnt};
    new_ovf = ovf_sticky | sum_ext[ACC_W];
`ifdef POPCOUNT_SAT_EN
    new_total = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    new_total = sum_ext[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_last  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_cnt  <= in_cnt;
        s1_last <= bus.in_last;
      end
    end
  end

  // Output fields only change on an advance, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_cnt   <= '0;
      s2_total <= '0;
      s2_last  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cnt   <= s1_cnt;
        s2_total <= new_total;
        s2_last  <= s1_last;
        s2_ovf   <= new_ovf;
      end
    end
  end

  // Clearing on the last word lets the next frame's first word add from zero
  // even while that last word is still waiting in S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (s1_to_s2) begin
      if (s1_last) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= new_total;
        ovf_sticky <= new_ovf;
      end
    end
  end

  assign bus.in_ready  = !rst && s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_cnt   = s2_cnt;
  assign bus.out_total = s2_total;
  assign bus.out_last  = s2_last;
  assign bus.out_ovf   = s2_ovf;
endmodule

// File: tb/tb_popcount_stream.sv
// Directed bench for popcount_stream: a 16-bit-total instance for function and
// handshake behaviour, and a 4-bit-total instance for wrap/saturate overflow.
module tb_popcount_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  popcount_stream_if #(.W(9), .ACC_W(16)) bus ();
  popcount_stream_if #(.W(9), .ACC_W(4))  bus4 ();

  popcount_stream #(.W(9), .ACC_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  popcount_stream #(.W(9), .ACC_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Entries: {last, ovf, total, cnt}
  logic [21:0] exp_q[$];
  logic [9:0]  exp4_q[$];
  logic [21:0] e;
  logic [9:0]  e4;

  logic [15:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  logic [8:0]  frame_w[5];
  logic [8:0]  bp_w[4];
  int          idx;
  logic [3:0]  snap_cnt;
  logic [15:0] snap_total;
  logic        snap_last;
  logic        snap_ovf;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: counts ones independently and keeps its own frame state.
  task automatic push_exp(input logic [8:0] d, input logic l);
    logic [16:0] s;
    logic [3:0]  c;
    c = 4'($countones(d));
    s = {1'b0, m_acc} + {13'd0, c};
    exp_q.push_back({l, m_ovf | s[16], s[15:0], c});
    if (l) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      m_acc = s[15:0];
      m_ovf = m_ovf | s[16];
    end
  endtask

  task automatic send(input logic [8:0] d, input logic l, input bit push);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", 32'(n < 40), 1);
    if (push && n < 40) push_exp(d, l);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [8:0] d, input logic l, input logic [9:0] exp);
    int n;
    n = 0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    bus4.in_last  = l;
    @(negedge clk);
    while (!bus4.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send4_ready_wait", 32'(n < 40), 1);
    if (n < 40) exp4_q.push_back(exp);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_cnt",   32'(bus.out_cnt),   32'(e[3:0]));
        chk("out_total", 32'(bus.out_total), 32'(e[19:4]));
        chk("out_ovf",   32'(bus.out_ovf),   32'(e[20]));
        chk("out_last",  32'(bus.out_last),  32'(e[21]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) begin
        chk("unexpected_out4", 32'(exp4_q.size()), 1);
      end else begin
        e4 = exp4_q.pop_front();
        chk("ovf_cnt",   32'(bus4.out_cnt),   32'(e4[3:0]));
        chk("ovf_total", 32'(bus4.out_total), 32'(e4[7:4]));
        chk("ovf_flag",  32'(bus4.out_ovf),   32'(e4[8]));
        chk("ovf_last",  32'(bus4.out_last),  32'(e4[9]));
      end
    end
  end

  initial begin
    int n;
    frame_w[0] = 9'h1BB; frame_w[1] = 9'h1BA; frame_w[2] = 9'h1B9;
    frame_w[3] = 9'h1BF; frame_w[4] = 9'h1B7;
    bp_w[0] = 9'h0F0; bp_w[1] = 9'h1FF; bp_w[2] = 9'h003; bp_w[3] = 9'h100;

    // Reset held 3 cycles while a word is offered.
    bus.in_valid  = 1'b1; bus.in_data  = 9'h1FF; bus.in_last  = 1'b1; bus.out_ready  = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_data = 9'h000; bus4.in_last = 1'b0; bus4.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    chk("post_rst_out_cnt",   32'(bus.out_cnt), 0);
    chk("post_rst_out_total", 32'(bus.out_total), 0);
    chk("post_rst_out_last",  32'(bus.out_last), 0);
    chk("post_rst_out_ovf",   32'(bus.out_ovf), 0);
    chk("post_rst_in_ready",  32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Five-word frame; first word also checks pipeline latency.
    send(frame_w[0], 1'b0, 1'b1);
    chk("lat_s1_only", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("lat_s2_valid", 32'(bus.out_valid), 1);
    chk("lat_s2_total", 32'(bus.out_total), 7);
    for (int i = 1; i < 5; i++) send(frame_w[i], 1'b0 | (i == 4), 1'b1);
    repeat (4) @(posedge clk); #1;

    // Back-to-back single-word frames with no bubble.
    send(9'h1FF, 1'b1, 1'b1);
    send(9'h001, 1'b1, 1'b1);
    chk("b2b_first_valid", 32'(bus.out_valid), 1);
    chk("b2b_first_total", 32'(bus.out_total), 9);
    @(posedge clk); #1;
    chk("b2b_second_valid", 32'(bus.out_valid), 1);
    chk("b2b_second_total", 32'(bus.out_total), 1);
    repeat (4) @(posedge clk); #1;

    // Backpressure: offer 4 words with out_ready low.
    bus.out_ready = 1'b0;
    idx = 0;
    bus.in_valid = 1'b1; bus.in_data = bp_w[0]; bus.in_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) begin
        snap_cnt = bus.out_cnt; snap_total = bus.out_total;
        snap_last = bus.out_last; snap_ovf = bus.out_ovf;
      end
      if (bus.in_ready && idx < 4) begin
        push_exp(bp_w[idx], 1'b0 | (idx == 3));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin
        bus.in_data = bp_w[idx];
        bus.in_last = (idx == 3);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted",    32'(idx), 2);
    chk("bp_in_ready",    32'(bus.in_ready), 0);
    chk("bp_out_valid",   32'(bus.out_valid), 1);
    chk("bp_hold_cnt",    32'(bus.out_cnt), 32'(snap_cnt));
    chk("bp_hold_total",  32'(bus.out_total), 32'(snap_total));
    chk("bp_hold_last",   32'(bus.out_last), 32'(snap_last));
    chk("bp_hold_ovf",    32'(bus.out_ovf), 32'(snap_ovf));
    chk("bp_head_total",  32'(bus.out_total), 4);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(bus.in_ready), 1);
    send(bp_w[2], 1'b0, 1'b1);
    send(bp_w[3], 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Overflow on the 4-bit-total instance, then a fresh frame.
`ifdef POPCOUNT_SAT_EN
    send4(9'h1FF, 1'b0, {1'b0, 1'b0, 4'd9,  4'd9});
    send4(9'h1FF, 1'b0, {1'b0, 1'b1, 4'd15, 4'd9});
    send4(9'h1FF, 1'b1, {1'b1, 1'b1, 4'd15, 4'd9});
`else
    send4(9'h1FF, 1'b0, {1'b0, 1'b0, 4'd9,  4'd9});
    send4(9'h1FF, 1'b0, {1'b0, 1'b1, 4'd2,  4'd9});
    send4(9'h1FF, 1'b1, {1'b1, 1'b1, 4'd11, 4'd9});
`endif
    send4(9'h003, 1'b1, {1'b1, 1'b0, 4'd2, 4'd2});
    repeat (4) @(posedge clk); #1;

    // Mid-frame reset: two stalled words are dropped with the partial total.
    bus.out_ready = 1'b0;
    send(9'h0FF, 1'b0, 1'b0);
    send(9'h0FF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    send(9'h00F, 1'b1, 1'b1);
    chk("midrst_exp_total", 32'(exp_q[0][19:4]), 4);

    n = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk); #1;
    chk("drain_exp_q",  32'(exp_q.size()), 0);
    chk("drain_exp4_q", 32'(exp4_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
